// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, decode and branch logic.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  // Fetch-unit side.
  modport master (
    output imem_addr,
    input  imem_inst,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    input  redirect_valid,
    input  redirect_pc,
    output fault,
    output fault_pc
  );

  // Environment side (memory, decode, branch unit).
  modport slave (
    input  imem_addr,
    output imem_inst,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    output redirect_valid,
    output redirect_pc,
    input  fault,
    input  fault_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Small pointer-based FIFO of {pc, inst} entries with flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, queues fetched words toward decode, handles redirects and faults.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 fetch_en,
  instr_fetch_unit_if.master  bus
);

  logic [31:0]  pc;
  logic         fault_q;
  logic [31:0]  fault_pc_q;
  logic         enq;
  logic         deq;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;
  fetch_entry_t q_din;

  assign bus.imem_addr = pc;
  assign q_din         = '{pc: pc, inst: bus.imem_inst};

  // Redirect blocks both enqueue and dequeue; a full queue never enqueues even when draining.
  assign enq           = fetch_en && !fault_q && !bus.redirect_valid && !q_full;
  assign bus.out_valid = !q_empty && !bus.redirect_valid;
  assign deq           = bus.out_valid && bus.out_ready;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (deq),
    .flush (bus.redirect_valid),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  // Program counter: redirect wins, otherwise advance one word per enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc;
    end else if (enq) begin
      pc <= pc + INST_BYTES;
    end
  end

  // Sticky misaligned-target fault; the first offending target is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (bus.redirect_valid && !fault_q && is_misaligned(bus.redirect_pc)) begin
      fault_q    <= 1'b1;
      fault_pc_q <= bus.redirect_pc;
    end
  end

  // Decode-facing head view; an empty queue presents pc 0 and a NOP.
  always_comb begin
    bus.out_pc   = '0;
    bus.out_inst = NOP_INST;
    if (!q_empty) begin
      bus.out_pc   = q_head.pc;
      bus.out_inst = q_head.inst;
    end
  end

  assign bus.fault    = fault_q;
  assign bus.fault_pc = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic        ehas;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ef;
    logic [31:0] efp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_en;
  int   checks = 0;
  int   errors = 0;
  vec_t vt [28];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_en (fetch_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.imem_inst = word(bus.imem_addr);

  function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic ev, input logic ehas,
                              input logic [31:0] epc, input logic [31:0] eaddr,
                              input logic ef, input logic [31:0] efp);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ehas = ehas; v.epc = epc; v.eaddr = eaddr;
    v.ef = ef; v.efp = efp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einst, input logic [31:0] eaddr,
                         input logic ef, input logic [31:0] efp);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".out_pc"},    bus.out_pc,         epc);
    chk({tag, ".out_inst"},  bus.out_inst,       einst);
    chk({tag, ".imem_addr"}, bus.imem_addr,      eaddr);
    chk({tag, ".fault"},     32'(bus.fault),     32'(ef));
    chk({tag, ".fault_pc"},  bus.fault_pc,       efp);
  endtask

  // Each vector: drive inputs, check settled outputs before the edge, then clock.
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      fetch_en           = vt[i].fe;
      bus.out_ready      = vt[i].rdy;
      bus.redirect_valid = vt[i].rv;
      bus.redirect_pc    = vt[i].rpc;
      #1;
      chk_all($sformatf("v%0d", i), vt[i].ev,
              vt[i].ehas ? vt[i].epc : 32'h0,
              vt[i].ehas ? word(vt[i].epc) : NOP,
              vt[i].eaddr, vt[i].ef, vt[i].efp);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            fe rdy rv rpc            ev has epc            addr           f  fpc
    vt[0]  = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,          0, 32'h0);
    vt[1]  = mk(1, 1, 0, 32'h0,          1, 1, 32'h0,          32'h4,          0, 32'h0);
    vt[2]  = mk(1, 1, 0, 32'h0,          1, 1, 32'h4,          32'h8,          0, 32'h0);
    vt[3]  = mk(1, 1, 0, 32'h0,          1, 1, 32'h8,          32'hC,          0, 32'h0);
    vt[4]  = mk(1, 0, 0, 32'h0,          1, 1, 32'hC,          32'h10,         0, 32'h0);
    vt[5]  = mk(1, 0, 0, 32'h0,          1, 1, 32'hC,          32'h14,         0, 32'h0);
    vt[6]  = mk(1, 0, 0, 32'h0,          1, 1, 32'hC,          32'h14,         0, 32'h0);
    vt[7]  = mk(1, 0, 0, 32'h0,          1, 1, 32'hC,          32'h14,         0, 32'h0);
    vt[8]  = mk(1, 0, 0, 32'h0,          1, 1, 32'hC,          32'h14,         0, 32'h0);
    vt[9]  = mk(1, 1, 0, 32'h0,          1, 1, 32'hC,          32'h14,         0, 32'h0);
    vt[10] = mk(1, 1, 0, 32'h0,          1, 1, 32'h10,         32'h14,         0, 32'h0);
    vt[11] = mk(1, 1, 0, 32'h0,          1, 1, 32'h14,         32'h18,         0, 32'h0);
    vt[12] = mk(1, 0, 0, 32'h0,          1, 1, 32'h18,         32'h1C,         0, 32'h0);
    vt[13] = mk(1, 0, 1, 32'h40,         0, 1, 32'h18,         32'h20,         0, 32'h0);
    vt[14] = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h40,         0, 32'h0);
    vt[15] = mk(1, 1, 0, 32'h0,          1, 1, 32'h40,         32'h44,         0, 32'h0);
    vt[16] = mk(1, 1, 1, 32'h42,         0, 1, 32'h44,         32'h48,         0, 32'h0);
    vt[17] = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h42,         1, 32'h42);
    vt[18] = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h42,         1, 32'h42);
    vt[19] = mk(1, 1, 1, 32'h80,         0, 0, 32'h0,          32'h42,         1, 32'h42);
    vt[20] = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h80,         1, 32'h42);
    vt[21] = mk(1, 1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          32'h0,          0, 32'h0);
    vt[22] = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'hFFFF_FFFC,  0, 32'h0);
    vt[23] = mk(1, 1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  32'h0,          0, 32'h0);
    vt[24] = mk(1, 1, 0, 32'h0,          1, 1, 32'h0,          32'h4,          0, 32'h0);
    vt[25] = mk(0, 1, 0, 32'h0,          1, 1, 32'h4,          32'h8,          0, 32'h0);
    vt[26] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          32'h8,          0, 32'h0);
    vt[27] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h8,          0, 32'h0);

    rst_n              = 1'b0;
    fetch_en           = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #12;
    chk_all("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // Streaming, back-pressure, aligned and misaligned redirects.
    run(0, 20);

    // Fault persists until reset.
    rst_n = 1'b0;
    #1;
    chk_all("fault_clear", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
    #1;
    rst_n              = 1'b1;
    fetch_en           = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("full", 1'b1, 32'h0, word(32'h0), 32'h8, 1'b0, 32'h0);

    // Asynchronous reset with a full queue discards entries without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
    #1;
    rst_n = 1'b1;

    // PC wrap and fetch_en low.
    run(21, 27);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage that owns the program counter.
- Drives the byte address into the combinational instruction memory and captures the returned word in the same cycle.
- Buffers {pc, inst} pairs in a small queue toward decode using a valid/ready handshake.
- Accepts branch/jump redirects, which flush the queue, and flags misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 2, fetch queue entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_en  input  1  when low, no new fetch is enqueued and PC holds.
- imem_addr  output  32  byte address to instruction memory; equals current PC.
- imem_inst  input  32  instruction word returned combinationally for imem_addr.
- out_valid  output  1  head queue entry is available to decode.
- out_ready  input  1  decode accepts the head entry this cycle.
- out_pc  output  32  PC of head entry.
- out_inst  output  32  instruction of head entry.
- redirect_valid  input  1  branch/jump taken; single-cycle pulse or held.
- redirect_pc  input  32  redirect target byte address.
- fault  output  1  sticky misaligned-redirect flag.
- fault_pc  output  32  target address that caused the fault.

Behaviour:
- Reset (async assert, sync-to-clk deassert by system): pc = RESET_PC, queue count = 0, fault = 0, fault_pc = 0.
- Output values in reset: out_valid = 0, out_pc = 0, out_inst = 32'h0000_0013 (NOP), imem_addr = RESET_PC.
- imem_addr = pc, purely combinational.
- Fetch latency is 1 cycle: a word sampled at edge N is visible on out_* after edge N.
- Enqueue condition: fetch_en && !fault && !redirect_valid && count < QDEPTH. On enqueue, push {pc, imem_inst} and set pc <= pc + 4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Full queue: no enqueue, even if a dequeue occurs in the same cycle (no full-bypass); pc holds.
- out_valid = (count != 0) && !redirect_valid.
- Dequeue when out_valid && out_ready.
- Simultaneous enqueue and dequeue with count < QDEPTH: count is unchanged.
- When empty: out_pc = 0, out_inst = NOP.
- Redirect has priority over everything:
  - count <= 0 (flush);
  - pc <= redirect_pc;
  - no enqueue or dequeue that cycle.
- Misaligned redirect (redirect_pc[1:0] != 0): additionally fault <= 1 and fault_pc <= redirect_pc.
- fault is sticky until reset. While fault = 1, fetching stops; entries already queued still drain.
- A redirect while fault = 1 updates pc but does not clear fault or change fault_pc.
- fetch_en low: pc and queue contents are held; dequeue proceeds normally.
- Reset asserted mid-operation discards all queued entries immediately.

Decomposition:
- Shared package fetch_pkg contains:
  - typedef fetch_entry_t, a packed struct {logic [31:0] pc; logic [31:0] inst};
  - constant NOP_INST = 32'h0000_0013;
  - constant INST_BYTES = 4.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t.
  - Parameterised by QDEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - Pointer-based with a count.
- instr_fetch_unit contains the PC register, enqueue/redirect control and fault logic.

Test Plan:
- Reset release, fetch_en = 1, out_ready = 1, memory word i = 0x1000_0000 + i → out_pc sequence 0, 4, 8, 12 on consecutive cycles with out_inst 0x1000_0000, 0x1000_0001, ...; first out_valid one cycle after reset release.
- out_ready = 0 for 5 cycles → count saturates at 2, pc holds at 8, out_pc stays 0. Raise out_ready → entries 0 and 4 drain, then 8 follows with no gap or duplicate.
- Redirect to 0x40 while queue holds PCs 0x10 and 0x14 → out_valid = 0 that cycle; next cycle queue empty, imem_addr = 0x40; following cycle out_pc = 0x40.
- Redirect to 0x42 → fault = 1, fault_pc = 0x42, no further enqueue, out_valid stays 0 after drain. A later redirect to 0x80 keeps fault_pc = 0x42; only rst_n clears fault.
- Redirect to 0xFFFF_FFFC → outputs out_pc 0xFFFF_FFFC, then 0x0000_0000 (wrap).
- Assert rst_n low mid-stream with queue full → out_valid = 0 immediately (async), out_inst = NOP; after release, fetch restarts at RESET_PC.
